// File: rtl/spi_master_regs_if.sv
// Register-bus link between the AXI-Lite slave adapter and the SPI master register block.
interface spi_master_regs_if;
   logic [31:0]  bus2ip_data;
   logic [3:0]   bus2ip_wrce;
   logic [3:0]   bus2ip_rdce;
   logic [127:0] ip2bus_data;
   logic         ip2bus_wrack;
   logic         ip2bus_rdack;

   modport master (
      output bus2ip_data, bus2ip_wrce, bus2ip_rdce,
      input  ip2bus_data, ip2bus_wrack, ip2bus_rdack
   );

   modport slave (
      input  bus2ip_data, bus2ip_wrce, bus2ip_rdce,
      output ip2bus_data, ip2bus_wrack, ip2bus_rdack
   );
endinterface

// File: rtl/spi_master_regs.sv
// SPI master register block: decodes adapter strobes into CTRL/STATUS/TXDATA/RXDATA
// and runs a single-slave 8-bit SPI engine with selectable CPOL/CPHA.
module spi_master_regs #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   spi_master_regs_if.slave bus,
   output logic             spi_sclk,
   output logic             spi_mosi,
   input  logic             spi_miso,
   output logic             spi_ss_n,
   output logic             irq
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLead  = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
   localparam logic [1:0] StTrail = 2'd3;
   localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

   logic [3:0]       wrce_prev_q, rdce_prev_q;
   logic             wrack_q, rdack_q;
   logic             enable_q, enable_d, cpol_q, cpol_d, cpha_q, cpha_d, irq_en_q, irq_en_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             rx_valid_q, rx_valid_d, tx_ovf_q, tx_ovf_d, done_q, done_d;
   logic [7:0]       txdata_q, txdata_d, rxdata_q, rxdata_d;
   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] half_cnt_q, half_cnt_d, div_lat_q, div_lat_d;
   logic [4:0]       tog_cnt_q, tog_cnt_d;
   logic             cpol_lat_q, cpol_lat_d, cpha_lat_q, cpha_lat_d;
   logic [7:0]       tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic             sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
   logic             wr_edge, rd_edge, wr_ctrl, wr_status, wr_tx, rd_rx;
   logic             busy, abort, start, toggle;
   logic [31:0]      ctrl_word;

   // Multi-bit strobes still produce an edge (and ack) but match no register.
   assign wr_edge   = (bus.bus2ip_wrce != 4'd0) && (wrce_prev_q == 4'd0);
   assign rd_edge   = (bus.bus2ip_rdce != 4'd0) && (rdce_prev_q == 4'd0);
   assign wr_ctrl   = wr_edge && (bus.bus2ip_wrce == 4'b0001);
   assign wr_status = wr_edge && (bus.bus2ip_wrce == 4'b0010);
   assign wr_tx     = wr_edge && (bus.bus2ip_wrce == 4'b0100);
   assign rd_rx     = rd_edge && (bus.bus2ip_rdce == 4'b1000);

   assign busy  = (state_q != StIdle);
   assign abort = busy && wr_ctrl && !bus.bus2ip_data[0];
   assign start = !busy && wr_tx && enable_q;

   always_comb begin
      enable_d   = enable_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      irq_en_d   = irq_en_q;
      div_d      = div_q;
      rx_valid_d = rx_valid_q;
      tx_ovf_d   = tx_ovf_q;
      done_d     = done_q;
      txdata_d   = txdata_q;
      rxdata_d   = rxdata_q;
      state_d    = state_q;
      half_cnt_d = half_cnt_q;
      div_lat_d  = div_lat_q;
      tog_cnt_d  = tog_cnt_q;
      cpol_lat_d = cpol_lat_q;
      cpha_lat_d = cpha_lat_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      ss_n_d     = ss_n_q;
      toggle     = 1'b0;

      if (wr_ctrl) begin
         enable_d = bus.bus2ip_data[0];
         cpol_d   = bus.bus2ip_data[1];
         cpha_d   = bus.bus2ip_data[2];
         irq_en_d = bus.bus2ip_data[3];
         div_d    = bus.bus2ip_data[8 +: DIV_W];
      end
      if (wr_status) begin
         if (bus.bus2ip_data[2]) tx_ovf_d = 1'b0;
         if (bus.bus2ip_data[3]) done_d = 1'b0;
      end
      if (rd_rx) rx_valid_d = 1'b0;
      if (wr_tx) begin
         txdata_d = bus.bus2ip_data[7:0];
         if (busy) tx_ovf_d = 1'b1;
      end

      if (abort) begin
         state_d = StIdle;
         ss_n_d  = 1'b1;
         sclk_d  = cpol_d;
      end else begin
         unique case (state_q)
            StIdle: begin
               ss_n_d = 1'b1;
               sclk_d = cpol_d;
               if (start) begin
                  state_d    = StLead;
                  ss_n_d     = 1'b0;
                  half_cnt_d = div_q;
                  div_lat_d  = div_q;
                  cpol_lat_d = cpol_q;
                  cpha_lat_d = cpha_q;
                  tog_cnt_d  = 5'd0;
                  // CPHA=0 presents bit 7 during LEAD; CPHA=1 drives it on the first edge.
                  if (cpha_q) begin
                     tx_sr_d = bus.bus2ip_data[7:0];
                  end else begin
                     mosi_d  = bus.bus2ip_data[7];
                     tx_sr_d = {bus.bus2ip_data[6:0], 1'b0};
                  end
               end
            end
            StLead, StShift: begin
               if (half_cnt_q != '0) begin
                  half_cnt_d = half_cnt_q - DivOne;
               end else begin
                  half_cnt_d = div_lat_q;
                  if (tog_cnt_q == 5'd16) begin
                     state_d = StTrail;
                  end else begin
                     state_d = StShift;
                     toggle  = 1'b1;
                  end
               end
            end
            StTrail: begin
               if (half_cnt_q != '0) begin
                  half_cnt_d = half_cnt_q - DivOne;
               end else begin
                  state_d    = StIdle;
                  ss_n_d     = 1'b1;
                  rxdata_d   = rx_sr_q;
                  rx_valid_d = 1'b1;
                  done_d     = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Odd toggles are the leading edge: sample there for CPHA=0, shift for CPHA=1.
      if (toggle) begin
         tog_cnt_d = tog_cnt_q + 5'd1;
         sclk_d    = ~sclk_q;
         if (tog_cnt_d[0] ^ cpha_lat_q) begin
            rx_sr_d = {rx_sr_q[6:0], spi_miso};
         end else begin
            mosi_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wrce_prev_q <= 4'd0;
         rdce_prev_q <= 4'd0;
         wrack_q     <= 1'b0;
         rdack_q     <= 1'b0;
         enable_q    <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         irq_en_q    <= 1'b0;
         div_q       <= '0;
         rx_valid_q  <= 1'b0;
         tx_ovf_q    <= 1'b0;
         done_q      <= 1'b0;
         txdata_q    <= 8'd0;
         rxdata_q    <= 8'd0;
         state_q     <= StIdle;
         half_cnt_q  <= '0;
         div_lat_q   <= '0;
         tog_cnt_q   <= 5'd0;
         cpol_lat_q  <= 1'b0;
         cpha_lat_q  <= 1'b0;
         tx_sr_q     <= 8'd0;
         rx_sr_q     <= 8'd0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ss_n_q      <= 1'b1;
      end else begin
         wrce_prev_q <= bus.bus2ip_wrce;
         rdce_prev_q <= bus.bus2ip_rdce;
         wrack_q     <= wr_edge;
         rdack_q     <= rd_edge;
         enable_q    <= enable_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         irq_en_q    <= irq_en_d;
         div_q       <= div_d;
         rx_valid_q  <= rx_valid_d;
         tx_ovf_q    <= tx_ovf_d;
         done_q      <= done_d;
         txdata_q    <= txdata_d;
         rxdata_q    <= rxdata_d;
         state_q     <= state_d;
         half_cnt_q  <= half_cnt_d;
         div_lat_q   <= div_lat_d;
         tog_cnt_q   <= tog_cnt_d;
         cpol_lat_q  <= cpol_lat_d;
         cpha_lat_q  <= cpha_lat_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         ss_n_q      <= ss_n_d;
      end
   end

   always_comb begin
      ctrl_word              = 32'd0;
      ctrl_word[0]           = enable_q;
      ctrl_word[1]           = cpol_q;
      ctrl_word[2]           = cpha_q;
      ctrl_word[3]           = irq_en_q;
      ctrl_word[8 +: DIV_W]  = div_q;
   end

   assign bus.ip2bus_data  = {{24'd0, rxdata_q},
                              {24'd0, txdata_q},
                              {28'd0, done_q, tx_ovf_q, rx_valid_q, busy},
                              ctrl_word};
   assign bus.ip2bus_wrack = wrack_q;
   assign bus.ip2bus_rdack = rdack_q;

   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_ss_n = ss_n_q;
   assign irq      = done_q & irq_en_q;

endmodule

// File: doc/spi_master_regs.md
# spi_master_regs

Register-mapped SPI master that sits directly downstream of the AXI-Lite slave adapter. Consumes its one-hot `bus2ip_wrce`/`bus2ip_rdce` strobes and `bus2ip_data`, returns `ip2bus_data`, `ip2bus_wrack` and `ip2bus_rdack`, and drives a single-slave, 8-bit, mode-selectable (CPOL/CPHA) SPI link.

## Interface
- `DIV_W`, 8: width of the SCLK divider field.
- `ACLK`  in  1  system clock, all logic on rising edge.
- `ARESETn`  in  1  asynchronous, active-low reset.
- `bus2ip_data`  in  32  write data from adapter.
- `bus2ip_wrce`  in  4  one-hot write strobe; bit i selects register i.
- `bus2ip_rdce`  in  4  one-hot read strobe; bit i selects register i.
- `ip2bus_data`  out  128  register i on bits [32i+31:32i], always driven.
- `ip2bus_wrack`  out  1  one-cycle write acknowledge.
- `ip2bus_rdack`  out  1  one-cycle read acknowledge.
- `spi_sclk`  out  1  serial clock.
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in.
- `spi_ss_n`  out  1  slave select, active low.
- `irq`  out  1  level interrupt, `done & irq_en`.

## Operation
- Reg0 CTRL (R/W): [0] enable, [1] CPOL, [2] CPHA, [3] irq_en, [8+DIV_W-1:8] div; other bits read 0.
- Reg1 STATUS: [0] busy (RO), [1] rx_valid (RO), [2] tx_ovf (W1C), [3] done (W1C).
- Reg2 TXDATA (W): [7:0] byte to send; reads return last written byte.
- Reg3 RXDATA (RO): [7:0] last received byte; reading clears rx_valid.
- Bus access: strobe edge detected (`wrce != 0` while previous cycle `wrce == 0`, same for rdce); action performed on that cycle; ack pulses exactly once on next cycle; strobe held longer produces no further action/ack. Strobes with >1 bit set: ignored, still acked.
- Writes to RO registers/bits: no effect, acked.
- TXDATA write with enable=1 and busy=0: start transfer. With busy=1 or enable=0: byte stored, no start, tx_ovf set (busy case only).
- Engine latches CPOL, CPHA, div at start; CTRL changes during transfer affect next transfer only, except enable.
- FSM: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
  - IDLE: ss_n=1, sclk=CPOL, busy=0.
  - LEAD: ss_n=0, mosi=bit7 (CPHA=0), one half-period.
  - SHIFT: 16 SCLK toggles, one per half-period. CPHA=0: sample MISO on odd toggles, shift MOSI on even. CPHA=1: shift on odd, sample on even.
  - TRAIL: sclk=CPOL, ss_n=0, one half-period; on exit RXDATA loaded, rx_valid=1, done=1.
- Half-period = div+1 ACLK cycles (div=0 -> 1 cycle).
- Writing enable=0 mid-transfer: abort to IDLE next cycle, ss_n=1, sclk=CPOL, RXDATA/rx_valid/done unchanged.
- Completion and RXDATA read same cycle: rx_valid stays 1. Completion and done W1C same cycle: done stays 1.

## Timing
- Reset (async assert, sync release): all registers 0, sclk=0, mosi=0, ss_n=1, acks=0, irq=0, FSM IDLE. Reset mid-transfer aborts immediately.
- Ack latency: strobe edge at cycle T -> ack high at T+1 only.
- Start write at T: busy=1 and ss_n=0 from T+1; transfer occupies 18*(div+1) cycles (LEAD 1, SHIFT 16, TRAIL 1 half-period); ss_n=1, busy=0, done=1 on first cycle after TRAIL.
- ip2bus_data reflects register state registered at each edge; read data valid in ack cycle.
- Back-to-back: new start accepted the first cycle busy=0.

## Test plan
- Reset with all inputs idle -> ss_n=1, sclk=0, ip2bus_data=0, acks 0.
- CTRL=0x0000_0001 (mode 0, div=0), TXDATA=0xA5, MISO loopback -> ss_n low 18 cycles, MOSI 1,0,1,0,0,1,0,1, RXDATA=0xA5, STATUS=0xA (done, rx_valid).
- CTRL=0x0000_0307 (CPOL=1, CPHA=1, div=3), TXDATA=0x3C, MISO tied 1 -> sclk idles 1, toggles every 4 cycles, 72-cycle transfer, RXDATA=0xFF.
- TXDATA write during busy -> ack, no restart, STATUS[2]=1; write STATUS=0x4 -> STATUS[2]=0.
- CTRL enable cleared at mid-SHIFT -> ss_n=1 next cycle, done stays 0, RXDATA unchanged.
- wrce held 5 cycles -> exactly one wrack pulse; RXDATA read -> rdack at T+1, rx_valid cleared; irq_en=1 with done=1 -> irq=1.
